// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL registers, a byte FIFO
// and an 8N1 serializer with a registered tx output.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_d;
  logic [15:0] bit_cnt, bit_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        tx_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [4:0]    count;
  logic          overflow, tx_en;

  logic wr_any, wr_txdata, wr_status, wr_ctrl;
  logic push, pop, drop, full, empty, busy;
  logic unused_bits;

  assign unused_bits = ^{wenable[3:1], addr[1:0], wdata[31:8]};

  assign full      = (count == DEPTH_C);
  assign empty     = (count == 5'd0);
  assign busy      = (state != IDLE);
  assign wr_any    = sel & wenable[0];
  assign wr_txdata = wr_any && (addr[3:2] == 2'd0);
  assign wr_status = wr_any && (addr[3:2] == 2'd1);
  assign wr_ctrl   = wr_any && (addr[3:2] == 2'd2);
  // A full FIFO still takes a write when the serializer pops in the same cycle.
  assign push      = wr_txdata && (!full || pop);
  assign drop      = wr_txdata && full && !pop;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_en && !empty) begin
          pop       = 1'b1;
          state_d   = START;
          bit_cnt_d = 16'd0;
          shreg_d   = mem[rptr];
        end
      end
      START: begin
        if (bit_cnt == BIT_LAST) begin
          state_d   = DATA;
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d = 16'd0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = shreg >> 1;
          end
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d = 16'd0;
          // Chain straight into the next frame so queued bytes leave without a gap.
          if (tx_en && !empty) begin
            pop     = 1'b1;
            state_d = START;
            shreg_d = mem[rptr];
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
      rptr     <= '0;
      wptr     <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      tx_en    <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
      if (drop)                       overflow <= 1'b1;
      else if (wr_status && wdata[3]) overflow <= 1'b0;
      if (wr_ctrl) tx_en <= wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr] <= wdata[7:0];
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      unique case (addr[3:2])
        2'd1:    rdata = {19'd0, count, 4'd0, overflow, empty, full, busy};
        2'd2:    rdata = {31'd0, tx_en};
        default: rdata = 32'd0;
      endcase
    end
  end
endmodule
